// File: rtl/hls_phi_add_unit.sv
// HLS datapath primitives: wrap-around adder, phi mux and
// last-basic-block tracker that steers the phi.

module br_dummy;
endmodule

module hls_phi_add_unit #(
  parameter int ADD_WIDTH = 32,
  parameter int PHI_WIDTH = 8,
  parameter int NB_PAIR   = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [ADD_WIDTH-1:0]           add_in0,
  input  logic [ADD_WIDTH-1:0]           add_in1,
  output logic [ADD_WIDTH-1:0]           add_out,
  input  logic [NB_PAIR*PHI_WIDTH-1:0]   phi_in,
  input  logic [NB_PAIR*32-1:0]          phi_s,
  output logic [PHI_WIDTH-1:0]           phi_out,
  input  logic                           bb_valid,
  input  logic [31:0]                    bb_id,
  output logic [31:0]                    last_block
);

  logic [31:0] last_q;

  br_dummy u_br_dummy ();

  assign add_out    = add_in0 + add_in1;
  assign last_block = last_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= '0;
    end else if (bb_valid) begin
      last_q <= bb_id;
    end
  end

  // Scan high to low so the lowest matching pair wins.
  always_comb begin
    phi_out = '0;
    for (int i = NB_PAIR - 1; i >= 0; i--) begin
      if (phi_s[i*32 +: 32] == last_q) begin
        phi_out = phi_in[i*PHI_WIDTH +: PHI_WIDTH];
      end
    end
  end

endmodule

// File: tb/tb_hls_phi_add_unit.sv
// Directed bench for hls_phi_add_unit: adder, reset,
// back edge, phi matching and a looping counter sweep.

module tb_hls_phi_add_unit;

  logic        clk;
  logic        rst;
  logic [31:0] add_in0;
  logic [31:0] add_in1;
  logic [31:0] add_out;
  logic [15:0] phi_in;
  logic [63:0] phi_s;
  logic [7:0]  phi_out;
  logic        bb_valid;
  logic [31:0] bb_id;
  logic [31:0] last_block;

  int errors;
  int checks;
  logic [7:0] cnt;

  hls_phi_add_unit #(
    .ADD_WIDTH(32),
    .PHI_WIDTH(8),
    .NB_PAIR(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .add_in0(add_in0),
    .add_in1(add_in1),
    .add_out(add_out),
    .phi_in(phi_in),
    .phi_s(phi_s),
    .phi_out(phi_out),
    .bb_valid(bb_valid),
    .bb_id(bb_id),
    .last_block(last_block)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    errors   = 0;
    checks   = 0;
    rst      = 1'b1;
    bb_valid = 1'b1;
    bb_id    = 32'd5;
    add_in0  = '0;
    add_in1  = '0;
    phi_in   = {8'h2A, 8'h00};
    phi_s    = {32'd1, 32'd0};
    tick();
    chk("rst_last", last_block, 32'd0);
    chk("rst_phi", {24'd0, phi_out}, 32'd0);

    add_in0 = 32'hFFFF_FFFF;
    add_in1 = 32'd1;
    #1;
    chk("add_wrap", add_out, 32'd0);
    add_in0 = 32'd7;
    add_in1 = 32'hFFFF_FFFE;
    #1;
    chk("add_neg", add_out, 32'd5);
    add_in0 = 32'd41;
    add_in1 = 32'd1;
    #1;
    chk("add_42", add_out, 32'd42);

    rst      = 1'b0;
    bb_valid = 1'b1;
    bb_id    = 32'd1;
    #1;
    chk("phi_uses_reg", {24'd0, phi_out}, 32'd0);
    tick();
    chk("back_last", last_block, 32'd1);
    chk("back_phi", {24'd0, phi_out}, 32'h2A);
    bb_valid = 1'b0;
    bb_id    = 32'd9;
    tick();
    chk("hold_last", last_block, 32'd1);
    chk("hold_phi", {24'd0, phi_out}, 32'h2A);

    bb_valid = 1'b1;
    bb_id    = 32'd7;
    tick();
    chk("nomatch_last", last_block, 32'd7);
    chk("nomatch_phi", {24'd0, phi_out}, 32'd0);

    phi_in = {8'h55, 8'h66};
    phi_s  = {32'd3, 32'd3};
    bb_id  = 32'd3;
    tick();
    chk("dup_phi", {24'd0, phi_out}, 32'h66);
    phi_s = {32'h0000_0003, 32'h8000_0003};
    #1;
    chk("full_eq_phi", {24'd0, phi_out}, 32'h55);
    phi_s = {32'h0000_0103, 32'h0000_0003};
    #1;
    chk("lowest_phi", {24'd0, phi_out}, 32'h66);

    rst    = 1'b1;
    phi_in = {8'h00, 8'h00};
    phi_s  = {32'd1, 32'd0};
    bb_id  = 32'd1;
    tick();
    rst = 1'b0;
    cnt = 8'd0;
    for (int k = 0; k < 300; k++) begin
      chk("sweep_phi", {24'd0, phi_out}, {24'd0, cnt});
      add_in0 = {24'd0, cnt};
      add_in1 = 32'd1;
      #1;
      phi_in   = {add_out[7:0], 8'h00};
      bb_valid = 1'b1;
      bb_id    = 32'd1;
      tick();
      cnt = cnt + 8'd1;
    end
    chk("sweep_last", last_block, 32'd1);

    rst = 1'b1;
    tick();
    chk("midrst_last", last_block, 32'd0);
    chk("midrst_phi", {24'd0, phi_out}, 32'd0);
    rst      = 1'b0;
    bb_valid = 1'b0;
    tick();
    chk("post_rst_hold", last_block, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
